// File: rtl/ks_envelope.sv
// ks_envelope: AHDSR-style amplitude envelope for a plucked-string voice.
// The envelope advances one step per sample (rising edge of lrck). A rising
// gate plucks the note into ATTACK. Dropping the gate releases the note.
// Optional build macro KS_ENV_RETRIGGER_EN: when defined, a gate rise restarts
// ATTACK from any state. When undefined, a rise is honoured only in IDLE or
// RELEASE.
module ks_envelope #(
    parameter int HOLD_W = 12
) (
    input  logic              lrck,
    input  logic              rst,
    input  logic              gate,
    input  logic [9:0]        attack_step,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic [3:0]        decay_shift,
    input  logic [9:0]        sustain,
    input  logic [3:0]        release_shift,
    output logic [9:0]        volume,
    output logic [2:0]        state,
    output logic              active
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_DECAY   = 3'd3,
        ST_SUSTAIN = 3'd4,
        ST_RELEASE = 3'd5
    } state_e;

    localparam logic [9:0]        VOL_MAX = 10'd1023;
    localparam logic [HOLD_W-1:0] CNT_ONE = HOLD_W'(1);

    state_e            state_q, state_d;
    logic [9:0]        vol_q, vol_d;
    logic              gate_q;
    logic [HOLD_W-1:0] cnt_q, cnt_d;

    logic        st_bad;
    logic        rise;
    logic        rise_ok;
    logic        rel_req;
    logic [10:0] attack_sum;
    logic        attack_sat;
    logic [10:0] decay_d;
    logic [11:0] decay_lim;
    logic        decay_hit;
    logic [10:0] rel_r;
    logic        rel_hit;

    // Codes 6 and 7 are unreachable. If they appear anyway, they fall back to IDLE.
    assign st_bad = (state_q[2:1] == 2'b11);
    assign rise   = gate && !gate_q;

`ifdef KS_ENV_RETRIGGER_EN
    assign rise_ok = rise;
`else
    assign rise_ok = rise && (state_q == ST_IDLE || state_q == ST_RELEASE);
`endif

    // A low gate releases any sounding phase. IDLE and RELEASE are excluded.
    assign rel_req = !gate && (state_q == ST_ATTACK || state_q == ST_HOLD ||
                               state_q == ST_DECAY  || state_q == ST_SUSTAIN);

    // The arithmetic is widened so that no step can wrap past 0, sustain or full scale.
    assign attack_sum = {1'b0, vol_q} + {1'b0, attack_step} + 11'd1;
    assign attack_sat = (attack_sum >= 11'd1023);
    assign decay_d    = {1'b0, vol_q >> decay_shift} + 11'd1;
    assign decay_lim  = {2'b00, sustain} + {1'b0, decay_d};
    assign decay_hit  = ({2'b00, vol_q} <= decay_lim);
    assign rel_r      = {1'b0, vol_q >> release_shift} + 11'd1;
    assign rel_hit    = ({1'b0, vol_q} <= rel_r);

    // State register, hold counter, volume register and gate history.
    always_ff @(posedge lrck) begin
        // NOTE: Sequential state uses non-blocking assignments. Every flop then
        // samples the values from before the edge, regardless of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            vol_q   <= '0;
            gate_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vol_q   <= vol_d;
            gate_q  <= gate;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and hold-counter logic. Priority: accepted rise, then release, then normal progression.
    always_comb begin
        // NOTE: Each signal gets a default before any branch. A missed path then holds
        // the current value instead of inferring a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (st_bad) begin
            state_d = ST_IDLE;
        end else if (rise_ok) begin
            state_d = ST_ATTACK;
        end else if (rel_req) begin
            state_d = ST_RELEASE;
        end else begin
            case (state_q)
                ST_ATTACK: begin
                    if (attack_sat) begin
                        if (hold_len == '0) begin
                            state_d = ST_DECAY;
                        end else begin
                            state_d = ST_HOLD;
                            cnt_d   = hold_len;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) state_d = ST_DECAY;
                end
                ST_DECAY: begin
                    if (decay_hit) state_d = (sustain == '0) ? ST_IDLE : ST_SUSTAIN;
                end
                ST_SUSTAIN: begin
                    if (sustain == '0) state_d = ST_IDLE;
                end
                ST_RELEASE: begin
                    if (rel_hit) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Next volume. A rise or a release keeps the current level for that sample.
    always_comb begin
        vol_d = vol_q;
        if (st_bad) begin
            vol_d = '0;
        end else if (!rise_ok && !rel_req) begin
            case (state_q)
                ST_ATTACK:  vol_d = attack_sat ? VOL_MAX : attack_sum[9:0];
                ST_HOLD:    vol_d = VOL_MAX;
                ST_DECAY:   vol_d = decay_hit ? sustain : (vol_q - decay_d[9:0]);
                ST_SUSTAIN: vol_d = sustain;
                ST_RELEASE: vol_d = rel_hit ? 10'd0 : (vol_q - rel_r[9:0]);
                default:    vol_d = '0;
            endcase
        end
    end

    assign volume = vol_q;
    assign state  = state_q;
    assign active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ks_envelope.sv
// tb_ks_envelope: directed scenarios with literal expectations, then randomized
// stimulus. A sample-level envelope model in the bench checks every output on every cycle.
module tb_ks_envelope;

    localparam int S_IDLE    = 0;
    localparam int S_ATTACK  = 1;
    localparam int S_HOLD    = 2;
    localparam int S_DECAY   = 3;
    localparam int S_SUSTAIN = 4;
    localparam int S_RELEASE = 5;

`ifdef KS_ENV_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic        lrck;
    logic        rst;
    logic        gate;
    logic [9:0]  attack_step;
    logic [11:0] hold_len;
    logic [3:0]  decay_shift;
    logic [9:0]  sustain;
    logic [3:0]  release_shift;
    logic [9:0]  volume;
    logic [2:0]  state;
    logic        active;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: current level, phase, previous gate and hold samples remaining.
    int m_vol       = 0;
    int m_st        = 0;
    int m_gate_prev = 0;
    int m_hold_left = 0;
    bit m_valid     = 1'b0;

    ks_envelope #(.HOLD_W(12)) dut (
        .lrck          (lrck),
        .rst           (rst),
        .gate          (gate),
        .attack_step   (attack_step),
        .hold_len      (hold_len),
        .decay_shift   (decay_shift),
        .sustain       (sustain),
        .release_shift (release_shift),
        .volume        (volume),
        .state         (state),
        .active        (active)
    );

    initial begin
        lrck = 1'b0;
        forever #5 lrck = ~lrck;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Envelope model, advanced once per sample from the input values seen at that edge.
    always @(posedge lrck) begin
        int  d;
        bit  rise;
        bit  take;
        bit  sounding;
        if (rst) begin
            m_vol = 0; m_st = S_IDLE; m_gate_prev = 0; m_hold_left = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            rise     = gate && (m_gate_prev == 0);
            take     = rise && (RETRIG || m_st == S_IDLE || m_st == S_RELEASE);
            sounding = (m_st >= S_ATTACK && m_st <= S_SUSTAIN);
            if (take) begin
                m_st = S_ATTACK;
            end else if (!gate && sounding) begin
                m_st = S_RELEASE;
            end else if (m_st == S_IDLE) begin
                m_vol = 0;
            end else if (m_st == S_ATTACK) begin
                m_vol = m_vol + int'(attack_step) + 1;
                if (m_vol >= 1023) begin
                    m_vol = 1023;
                    if (hold_len == 0) m_st = S_DECAY;
                    else begin m_st = S_HOLD; m_hold_left = int'(hold_len); end
                end
            end else if (m_st == S_HOLD) begin
                m_vol = 1023;
                m_hold_left = m_hold_left - 1;
                if (m_hold_left == 0) m_st = S_DECAY;
            end else if (m_st == S_DECAY) begin
                d = (m_vol >> decay_shift) + 1;
                if (m_vol <= int'(sustain) + d) begin
                    m_vol = int'(sustain);
                    m_st  = (sustain == 0) ? S_IDLE : S_SUSTAIN;
                end else m_vol = m_vol - d;
            end else if (m_st == S_SUSTAIN) begin
                m_vol = int'(sustain);
                if (sustain == 0) m_st = S_IDLE;
            end else begin
                d = (m_vol >> release_shift) + 1;
                if (m_vol <= d) begin m_vol = 0; m_st = S_IDLE; end
                else m_vol = m_vol - d;
            end
            m_gate_prev = int'(gate);
        end
    end

    // Compare the DUT against the model on every falling edge once reset has been seen.
    always @(negedge lrck) begin
        if (m_valid) begin
            check("model_volume", int'(volume), m_vol);
            check("model_state",  int'(state),  m_st);
            check("model_active", int'(active), int'(m_st != S_IDLE));
        end
    end

    task automatic expect_vs(input string name, input int vol, input int st);
        check({name, "_vol"},   int'(volume), vol);
        check({name, "_state"}, int'(state),  st);
    endtask

    task automatic wait_for(input string name, input int st, input int vol, input int budget);
        bit hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge lrck);
            if (int'(state) == st && int'(volume) == vol) hit = 1'b1;
        end
        check(name, int'(hit), 1);
    endtask

    initial begin
        rst = 1'b1; gate = 1'b0; attack_step = 10'd255; hold_len = 12'd2;
        decay_shift = 4'd2; sustain = 10'd600; release_shift = 4'd0;
        repeat (2) @(negedge lrck);
        expect_vs("reset", 0, S_IDLE);
        check("reset_active", int'(active), 0);
        rst = 1'b0;

        // Pluck from IDLE: attack in steps of 256, two samples of hold, then decay to sustain.
        gate = 1'b1;
        @(negedge lrck); expect_vs("pluck", 0, S_ATTACK);
        @(negedge lrck); expect_vs("atk1", 256, S_ATTACK);
        @(negedge lrck); expect_vs("atk2", 512, S_ATTACK);
        @(negedge lrck); expect_vs("atk3", 768, S_ATTACK);
        @(negedge lrck); expect_vs("atk_full", 1023, S_HOLD);
        @(negedge lrck); expect_vs("hold2", 1023, S_HOLD);
        @(negedge lrck); expect_vs("hold_end", 1023, S_DECAY);
        @(negedge lrck); expect_vs("decay1", 767, S_DECAY);
        @(negedge lrck); expect_vs("decay_sus", 600, S_SUSTAIN);
        sustain = 10'd500;
        @(negedge lrck); expect_vs("sus_follow", 500, S_SUSTAIN);
        sustain = 10'd600;
        @(negedge lrck); expect_vs("sus_back", 600, S_SUSTAIN);

        // Release at a shift of 0 finishes in a single step.
        gate = 1'b0;
        @(negedge lrck); expect_vs("rel_enter", 600, S_RELEASE);
        @(negedge lrck); expect_vs("rel_done", 0, S_IDLE);
        check("rel_active", int'(active), 0);

        // Release during decay, then a re-pluck from RELEASE restarts attack at the current level.
        gate = 1'b1;
        wait_for("reach_decay767", S_DECAY, 767, 40);
        gate = 1'b0;
        @(negedge lrck); expect_vs("retrig_rel", 767, S_RELEASE);
        gate = 1'b1;
        @(negedge lrck); expect_vs("retrig_atk", 767, S_ATTACK);
        @(negedge lrck); expect_vs("retrig_full", 1023, S_HOLD);

        // Reset mid-attack, with the gate held high through the reset.
        gate = 1'b0;
        wait_for("reach_idle", S_IDLE, 0, 20);
        gate = 1'b1;
        @(negedge lrck); expect_vs("r2_pluck", 0, S_ATTACK);
        @(negedge lrck); expect_vs("r2_atk1", 256, S_ATTACK);
        @(negedge lrck); expect_vs("r2_atk2", 512, S_ATTACK);
        rst = 1'b1;
        @(negedge lrck); expect_vs("mid_reset", 0, S_IDLE);
        rst = 1'b0;
        @(negedge lrck); expect_vs("post_reset_rise", 0, S_ATTACK);

        // Sustain of 0 with no hold: decay drops straight to IDLE.
        hold_len = 12'd0; sustain = 10'd0; decay_shift = 4'd0;
        @(negedge lrck); expect_vs("s0_atk1", 256, S_ATTACK);
        @(negedge lrck); expect_vs("s0_atk2", 512, S_ATTACK);
        @(negedge lrck); expect_vs("s0_atk3", 768, S_ATTACK);
        @(negedge lrck); expect_vs("s0_nohold", 1023, S_DECAY);
        @(negedge lrck); expect_vs("s0_idle", 0, S_IDLE);

        // Randomized phase. The model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) gate = ~gate;
            attack_step   = 10'($urandom_range(0, 1023));
            hold_len      = 12'($urandom_range(0, 4));
            decay_shift   = 4'($urandom_range(0, 7));
            release_shift = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0)
                sustain = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            rst = ($urandom_range(0, 299) == 0);
            @(negedge lrck);
        end
        rst = 1'b0;
        @(negedge lrck);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
